j1_uart_tx: RTL

- Memory-mapped UART transmitter on the j1 I/O bus; consumes the CPU's io_wr/io_addr/io_dout cycles and serialises bytes onto txd.
- Drives io_din back to the CPU for status reads.
- Sits directly downstream of the j1 core, beside other I/O peripherals.
- Contains an 8-entry byte FIFO so firmware can burst writes without polling per byte.

---
 rtl/j1_io_pkg.sv | 21 ++
 rtl/j1_sync_fifo.sv | 54 +++++
 rtl/j1_uart_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/j1_io_pkg.sv
// Shared definitions for j1 I/O peripherals: register offsets, status bit
// positions and the UART transmitter state encoding.
package j1_io_pkg;

  localparam logic [15:0] OFS_DATA   = 16'd0;
  localparam logic [15:0] OFS_STATUS = 16'd1;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/j1_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; pushes to a full FIFO and pops
// from an empty one are ignored.
module j1_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head entry is visible without a read cycle so the consumer can pop and use it at once.
  assign rdata   = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/j1_uart_tx.sv
// Memory-mapped UART transmitter with byte FIFO for the j1 I/O bus.
// Define J1_UART_TX_PARITY_EN to append an even-parity bit (8E1 instead of 8N1).
import j1_io_pkg::*;

module j1_uart_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'hF000,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  input  logic        io_wr,
  input  logic        io_rd,
  output logic [15:0] io_din,
  output logic        txd,
  output logic        tx_busy
);
  localparam logic [15:0] DATA_ADDR = BASE_ADDR + OFS_DATA;
  localparam logic [15:0] STAT_ADDR = BASE_ADDR + OFS_STATUS;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  tx_state_t   state_reg, state_next;
  logic [15:0] baud_reg, baud_next;
  logic [7:0]  shift_reg, shift_next;
  logic [2:0]  bit_reg, bit_next;
  logic        txd_reg, txd_next;
  logic        ovf_reg;
`ifdef J1_UART_TX_PARITY_EN
  logic        par_reg, par_next;
`endif

  logic        wr_data, wr_stat, baud_done;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        unused_dout_hi;

  assign wr_data        = io_wr && (io_addr == DATA_ADDR);
  assign wr_stat        = io_wr && (io_addr == STAT_ADDR);
  assign baud_done      = (baud_reg == 16'd0);
  assign unused_dout_hi = ^io_dout[15:8];

  j1_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sys_clk_i),
    .srst  (sys_rst_i),
    .push  (wr_data),
    .wdata (io_dout[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
    fifo_pop   = 1'b0;
`ifdef J1_UART_TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_rdata;
          baud_next  = BAUD_LAST;
          state_next = START;
`ifdef J1_UART_TX_PARITY_EN
          par_next   = ^fifo_rdata;
`endif
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = BAUD_LAST;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg - 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next  = BAUD_LAST;
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef J1_UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          baud_next = baud_reg - 1'b1;
        end
      end
`ifdef J1_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_next  = BAUD_LAST;
          state_next = STOP;
        end else begin
          baud_next = baud_reg - 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_next  = 16'd0;
          state_next = IDLE;
        end else begin
          baud_next = baud_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // txd is registered from the next state so the line never glitches.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
`ifdef J1_UART_TX_PARITY_EN
      PARITY:  txd_next = par_next;
`endif
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_reg <= IDLE;
      baud_reg  <= 16'd0;
      shift_reg <= 8'd0;
      bit_reg   <= 3'd0;
      txd_reg   <= 1'b1;
      ovf_reg   <= 1'b0;
`ifdef J1_UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      shift_reg <= shift_next;
      bit_reg   <= bit_next;
      txd_reg   <= txd_next;
`ifdef J1_UART_TX_PARITY_EN
      par_reg   <= par_next;
`endif
      if (wr_stat) begin
        ovf_reg <= 1'b0;
      end else if (wr_data && fifo_full) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign txd     = txd_reg;
  assign tx_busy = (state_reg != IDLE) || !fifo_empty;

  always_comb begin
    io_din = 16'h0000;
    if (io_rd) begin
      if (io_addr == STAT_ADDR) begin
        io_din[ST_OVF]   = ovf_reg;
        io_din[ST_BUSY]  = tx_busy;
        io_din[ST_EMPTY] = fifo_empty;
        io_din[ST_FULL]  = fifo_full;
      end else if (io_addr == DATA_ADDR) begin
        io_din[ST_FULL] = fifo_full;
      end
    end
  end

endmodule
